sine_seq_ctrl: RTL and testbench

Sequencer for the free-running sine oscillator datapath in the oscilloscope signal source. It issues the oscillator's clear and step-enable strobes:
- clear restarts the oscillator at phase 0;
- the step rate comes from a programmable clock divider.

It also captures each new 8-bit offset-binary sample and counts completed periods, using midscale rising crossings. It runs either continuously or in burst mode, stopping after a programmed number of periods. Downstream display/trigger logic uses its `sample_valid` / `sample_out` stream and `busy` / `done` status.

---
 rtl/sine_seq_ctrl.sv | 119 +++++++++++
 tb/tb_sine_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sine_seq_ctrl.sv
// Sequencer for the sine oscillator: issues clear/step strobes, captures each new
// sample and counts midscale rising crossings, continuous or in bursts of periods.
module sine_seq_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             burst,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [7:0]       sample_in,
    output logic             osc_clr,
    output logic             osc_en,
    output logic             sample_valid,
    output logic [7:0]       sample_out,
    output logic [CNT_W-1:0] period_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Handshake: start is a one-cycle request taken only in IDLE; stop aborts
    // from CLR/RUN on the next edge and beats a simultaneous start in IDLE.

    logic [1:0]       state;
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] dcnt;
    logic [CNT_W-1:0] len_l;
    logic             burst_l;
    logic             cap_pend;
    logic             prev_msb;

    logic             rise;
    logic             inc;
    logic             term;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next  = period_cnt + 1'b1;
    assign rise      = cap_pend & ~prev_msb & sample_in[7];
    assign inc       = rise & (period_cnt != {CNT_W{1'b1}});
    // Burst end is decided in the capture cycle so a coinciding step is dropped.
    assign term      = (state == S_RUN) & burst_l & inc & (cnt_next == len_l);
    assign osc_en    = (state == S_RUN) & (dcnt == div_l) & ~term;
    assign osc_clr   = (state == S_CLR);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            div_l        <= '0;
            dcnt         <= '0;
            len_l        <= '0;
            burst_l      <= 1'b0;
            cap_pend     <= 1'b0;
            prev_msb     <= 1'b1;
            sample_valid <= 1'b0;
            sample_out   <= 8'd128;
            period_cnt   <= '0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            sample_valid <= cap_pend;
            cap_pend     <= osc_en;
            if (cap_pend) begin
                sample_out <= sample_in;
                prev_msb   <= sample_in[7];
                if (inc) begin
                    period_cnt <= cnt_next;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        div_l   <= div;
                        len_l   <= burst_len;
                        burst_l <= burst;
                        state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    cap_pend     <= 1'b0;
                    sample_valid <= 1'b0;
                    sample_out   <= 8'd128;
                    period_cnt   <= '0;
                    dcnt         <= '0;
                    prev_msb     <= 1'b1;
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (burst_l && (len_l == '0)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    dcnt <= (dcnt == div_l) ? '0 : dcnt + 1'b1;
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (term) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Self-checking bench for sine_seq_ctrl: oscillator model, directed runs and a
// sample scoreboard keyed on {period_cnt, sample_out}.
module tb_sine_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        burst = 1'b0;
    logic [15:0] div = '0;
    logic [7:0]  burst_len = '0;
    logic [7:0]  sample_in;
    logic        osc_clr, osc_en, sample_valid, busy, done;
    logic [7:0]  sample_out, period_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    sine_seq_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .burst(burst),
        .div(div), .burst_len(burst_len), .sample_in(sample_in),
        .osc_clr(osc_clr), .osc_en(osc_en), .sample_valid(sample_valid),
        .sample_out(sample_out), .period_cnt(period_cnt), .busy(busy),
        .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Oscillator model: 8-step sine, or a forced sequence indexed by phase-1.
    int   phase = 0;
    logic forced_mode = 1'b0;
    logic [7:0] sine_tab [8] = '{8'd128, 8'd218, 8'd255, 8'd218, 8'd128, 8'd37, 8'd0, 8'd37};
    logic [7:0] forced_tab [5] = '{8'd127, 8'd128, 8'd200, 8'd100, 8'd130};

    always @(posedge clk or posedge reset) begin
        if (reset) phase <= 0;
        else if (osc_clr) phase <= 0;
        else if (osc_en) phase <= phase + 1;
    end

    always @* begin
        if (forced_mode) sample_in = (phase >= 1 && phase <= 5) ? forced_tab[phase-1] : 8'd130;
        else sample_in = sine_tab[phase % 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every sample_valid pops one expected {period_cnt, sample_out}.
    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=%0d expected=none at %0t", sample_out, $time);
            end else begin
                chk("sample_stream", {period_cnt, sample_out}, exp_q.pop_front());
            end
        end
    end

    task automatic do_start(input logic b, input logic [15:0] d, input logic [7:0] len);
        @(negedge clk);
        start = 1'b1; burst = b; div = d; burst_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_sine(input int first, input int last);
        for (int k = first; k <= last; k++) exp_q.push_back({8'(k / 8), sine_tab[k % 8]});
    endtask

    int en_cnt, done_cnt, done_cyc;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_osc_clr", osc_clr, 0);
        chk("rst_osc_en", osc_en, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample_out", sample_out, 128);
        chk("rst_period_cnt", period_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Continuous, div=3, stray start mid-run, stop with a capture in flight.
        push_sine(1, 5);
        do_start(1'b0, 16'd3, 8'd0);
        chk("cont_clr_pulse", osc_clr, 1);
        chk("cont_clr_busy", busy, 1);
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            chk("cont_osc_en", osc_en, (c <= 21 && c % 4 == 0));
            chk("cont_sample_valid", sample_valid, (c >= 6 && c <= 22 && c % 4 == 2));
            chk("cont_busy", busy, (c <= 21));
            chk("cont_done", done, 0);
            if (c == 9) begin start = 1'b1; burst = 1'b1; div = 16'd0; burst_len = 8'd1; end
            if (c == 10) begin start = 1'b0; burst = 1'b0; div = 16'd3; end
            if (c == 21) stop = 1'b1;
            if (c == 22) stop = 1'b0;
        end
        chk("cont_queue_drained", exp_q.size(), 0);

        // Burst of two sine periods at div=0.
        push_sine(1, 16);
        do_start(1'b1, 16'd0, 8'd2);
        en_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (osc_en) en_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
        end
        chk("burst_en_count", en_cnt, 16);
        chk("burst_done_count", done_cnt, 1);
        chk("burst_done_cycle", done_cyc, 18);
        chk("burst_period_cnt", period_cnt, 2);
        chk("burst_idle", busy, 0);
        chk("burst_queue_drained", exp_q.size(), 0);

        // Zero-length burst: clear only, immediate done.
        do_start(1'b1, 16'd0, 8'd0);
        chk("zero_clr", osc_clr, 1);
        en_cnt = osc_en;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (osc_en) en_cnt++;
            chk("zero_done_once", done, 0);
        end
        chk("zero_en_count", en_cnt, 0);

        // start and stop together in IDLE.
        @(negedge clk);
        start = 1'b1; stop = 1'b1; burst = 1'b0; div = 16'd1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ss_no_clr", osc_clr, 0);
            chk("ss_idle", busy, 0);
            @(negedge clk);
        end

        // Forced crossing sequence at div=0, two-period burst.
        forced_mode = 1'b1;
        exp_q.push_back({8'd0, 8'd127});
        exp_q.push_back({8'd1, 8'd128});
        exp_q.push_back({8'd1, 8'd200});
        exp_q.push_back({8'd1, 8'd100});
        exp_q.push_back({8'd2, 8'd130});
        do_start(1'b1, 16'd0, 8'd2);
        en_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (osc_en) en_cnt++;
            if (done) done_cyc = c;
        end
        chk("forced_done_cycle", done_cyc, 7);
        chk("forced_en_count", en_cnt, 5);
        chk("forced_period_cnt", period_cnt, 2);
        repeat (3) @(negedge clk);
        chk("forced_queue_drained", exp_q.size(), 0);
        forced_mode = 1'b0;

        // Asynchronous reset mid-run at div=2, then during CLR.
        exp_q.push_back({8'd0, 8'd218});
        do_start(1'b0, 16'd2, 8'd0);
        for (int c = 1; c <= 6; c++) @(negedge clk);
        chk("rr_en_before", osc_en, 1);
        chk("rr_sample_before", sample_out, 218);
        reset = 1'b1;
        #1;
        chk("rr_osc_en", osc_en, 0);
        chk("rr_busy", busy, 0);
        chk("rr_osc_clr", osc_clr, 0);
        chk("rr_sample_out", sample_out, 128);
        chk("rr_period_cnt", period_cnt, 0);
        chk("rr_sample_valid", sample_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        do_start(1'b0, 16'd2, 8'd0);
        chk("rc_clr_before", osc_clr, 1);
        reset = 1'b1;
        #1;
        chk("rc_osc_clr", osc_clr, 0);
        chk("rc_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rc_stays_idle", busy, 0);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
